cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/fcs_seq_pkg.sv | 29 ++
 rtl/sync2.sv | 24 ++
 rtl/cpu_sequencer.sv | 106 ++++++++++
 tb/tb_cpu_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fcs_seq_pkg.sv
// Shared definitions for the board power sequencers: state encodings and
// default cycle counts for the CPU sequencer, plus the C66x DSP sequencer states.
package fcs_seq_pkg;

    typedef enum logic [2:0] {
        CPU_OFF         = 3'd0,
        CPU_WAIT_DSP    = 3'd1,
        CPU_PWRON       = 3'd2,
        CPU_WAIT_RSTOUT = 3'd3,
        CPU_HUB_RST     = 3'd4,
        CPU_RUN         = 3'd5,
        CPU_FAULT       = 3'd6,
        CPU_ILLEGAL     = 3'd7
    } cpu_state_e;

    typedef enum logic [2:0] {
        DSP_OFF     = 3'd0,
        DSP_PWR_UP  = 3'd1,
        DSP_RST_REL = 3'd2,
        DSP_RUN     = 3'd3,
        DSP_FAULT   = 3'd4
    } dsp_state_e;

    localparam logic [23:0] PWRON_CYCLES_DEF   = 24'h400000;
    localparam logic [23:0] RSTOUT_TIMEOUT_DEF = 24'hFFFFFF;
    localparam logic [23:0] HUB_RST_CYCLES_DEF = 24'h004000;
    localparam logic [23:0] TIMER_MAX          = 24'hFFFFFF;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous board-level inputs.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cpu_sequencer.sv
// CPU power-up sequencer: releases the PMIC after the DSP is running, waits for
// CPU reset-out, pulses the USB hub reset and supervises the CPU while running.
//   state       | meaning
//   OFF         | idle, CPU held off
//   WAIT_DSP    | enabled, waiting for the DSP sequencer
//   PWRON       | PMIC released, settling delay
//   WAIT_RSTOUT | waiting for synchronised cpu_resetout
//   HUB_RST     | USB hub / bridge reset pulse
//   RUN         | CPU up
//   FAULT       | reset-out timeout, held until enable drops
module cpu_sequencer
    import fcs_seq_pkg::*;
#(
    parameter logic [23:0] PWRON_CYCLES   = PWRON_CYCLES_DEF,
    parameter logic [23:0] RSTOUT_TIMEOUT = RSTOUT_TIMEOUT_DEF,
    parameter logic [23:0] HUB_RST_CYCLES = HUB_RST_CYCLES_DEF
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       enable,
    input  logic       dsp_ready,
    input  logic       cpu_resetout,
    output logic       pmic_pwron_hold,
    output logic       usbhub_reset_INV,
    output logic       cpu_running,
    output logic       fault,
    output logic [2:0] state
);

    cpu_state_e  state_q, state_d;
    logic [23:0] timer_q;
    logic        rso_s;
    logic        pmic_hold_q, pmic_hold_d;
    logic        hub_rst_n_q, hub_rst_n_d;
    logic        running_q, running_d;
    logic        fault_q, fault_d;

    sync2 u_rso_sync (
        .clk_i (sysclk),
        .rst_i (reset),
        .d_i   (cpu_resetout),
        .q_o   (rso_s)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_OFF:         if (enable) state_d = CPU_WAIT_DSP;
            CPU_WAIT_DSP:    if (dsp_ready) state_d = CPU_PWRON;
            CPU_PWRON:       if (timer_q == PWRON_CYCLES - 24'd1) state_d = CPU_WAIT_RSTOUT;
            CPU_WAIT_RSTOUT: begin
                // Reset-out seen on the timeout cycle still counts as success.
                if (rso_s)                                    state_d = CPU_HUB_RST;
                else if (timer_q == RSTOUT_TIMEOUT - 24'd1)   state_d = CPU_FAULT;
            end
            CPU_HUB_RST:     if (timer_q == HUB_RST_CYCLES - 24'd1) state_d = CPU_RUN;
            CPU_RUN:         if (!rso_s) state_d = CPU_WAIT_RSTOUT;
            CPU_FAULT:       state_d = CPU_FAULT;
            default:         state_d = CPU_OFF;
        endcase

        if (!enable) begin
            state_d = CPU_OFF;
        end else if (!dsp_ready && (state_q == CPU_PWRON || state_q == CPU_WAIT_RSTOUT ||
                                    state_q == CPU_HUB_RST || state_q == CPU_RUN)) begin
            state_d = CPU_OFF;
        end
    end

    // Outputs decode the next state so they move on the same edge as state_q.
    always_comb begin
        pmic_hold_d = (state_d == CPU_OFF) || (state_d == CPU_WAIT_DSP) || (state_d == CPU_FAULT);
        hub_rst_n_d = (state_d == CPU_RUN);
        running_d   = (state_d == CPU_RUN);
        fault_d     = (state_d == CPU_FAULT);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= CPU_OFF;
            timer_q     <= 24'd0;
            pmic_hold_q <= 1'b1;
            hub_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pmic_hold_q <= pmic_hold_d;
            hub_rst_n_q <= hub_rst_n_d;
            running_q   <= running_d;
            fault_q     <= fault_d;
            if (state_d != state_q) begin
                timer_q <= 24'd0;
            end else if (timer_q != TIMER_MAX) begin
                timer_q <= timer_q + 24'd1;
            end
        end
    end

    assign pmic_pwron_hold  = pmic_hold_q;
    assign usbhub_reset_INV = hub_rst_n_q;
    assign cpu_running      = running_q;
    assign fault            = fault_q;
    assign state            = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with shortened timing parameters.
module tb_cpu_sequencer;
    import fcs_seq_pkg::*;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       dsp_ready = 1'b0;
    logic       cpu_resetout = 1'b0;
    logic       pmic_pwron_hold;
    logic       usbhub_reset_INV;
    logic       cpu_running;
    logic       fault;
    logic [2:0] state;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    cpu_sequencer #(
        .PWRON_CYCLES   (24'd8),
        .RSTOUT_TIMEOUT (24'd32),
        .HUB_RST_CYCLES (24'd4)
    ) dut (
        .sysclk           (sysclk),
        .reset            (reset),
        .enable           (enable),
        .dsp_ready        (dsp_ready),
        .cpu_resetout     (cpu_resetout),
        .pmic_pwron_hold  (pmic_pwron_hold),
        .usbhub_reset_INV (usbhub_reset_INV),
        .cpu_running      (cpu_running),
        .fault            (fault),
        .state            (state)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge sysclk);
        cyc++;
        @(negedge sysclk);
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    // {pmic_pwron_hold, usbhub_reset_INV, cpu_running, fault}
    function automatic logic [31:0] outs();
        return {28'd0, pmic_pwron_hold, usbhub_reset_INV, cpu_running, fault};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge sysclk);
        step();
        step();
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_outs", outs(), 32'b1000);
        reset = 1'b0;
        cyc   = 0;

        // Nominal power-up
        enable = 1'b1;
        run_to(10);
        chk("nom_wait_dsp", {29'd0, state}, 32'd1);
        chk("nom_hold_c10", outs(), 32'b1000);
        dsp_ready = 1'b1;
        run_to(11);
        chk("nom_pwron", {29'd0, state}, 32'd2);
        chk("nom_hold_fall", outs(), 32'b0000);
        run_to(18);
        chk("nom_pwron_c18", {29'd0, state}, 32'd2);
        run_to(19);
        chk("nom_wait_rso_c19", {29'd0, state}, 32'd3);
        run_to(30);
        cpu_resetout = 1'b1;
        run_to(32);
        chk("nom_wait_rso_c32", {29'd0, state}, 32'd3);
        run_to(33);
        chk("nom_hub_rst_c33", {29'd0, state}, 32'd4);
        chk("nom_hub_outs", outs(), 32'b0000);
        run_to(36);
        chk("nom_hub_rst_c36", {29'd0, state}, 32'd4);
        run_to(37);
        chk("nom_run_c37", {29'd0, state}, 32'd5);
        chk("nom_run_outs", outs(), 32'b0110);

        // CPU self-reset while running
        run_to(40);
        cpu_resetout = 1'b0;
        run_to(42);
        chk("sr_still_run", {29'd0, state}, 32'd5);
        run_to(43);
        chk("sr_wait_rso", {29'd0, state}, 32'd3);
        chk("sr_outs", outs(), 32'b0000);
        run_to(45);
        cpu_resetout = 1'b1;
        run_to(47);
        chk("sr_wait_c47", {29'd0, state}, 32'd3);
        run_to(48);
        chk("sr_hub_rst", {29'd0, state}, 32'd4);
        run_to(51);
        chk("sr_hub_c51", {29'd0, state}, 32'd4);
        run_to(52);
        chk("sr_run", {29'd0, state}, 32'd5);
        chk("sr_run_outs", outs(), 32'b0110);

        // Sub-cycle glitch low on cpu_resetout, clear of any rising edge
        run_to(55);
        #1 cpu_resetout = 1'b0;
        #2 cpu_resetout = 1'b1;
        run_to(58);
        chk("glitch_state", {29'd0, state}, 32'd5);
        chk("glitch_outs", outs(), 32'b0110);

        // Illegal encoding held across one edge; outputs must decode OFF
        run_to(60);
        force dut.state_q = CPU_ILLEGAL;
        step();
        chk("illegal_outs", outs(), 32'b1000);
        release dut.state_q;
        enable = 1'b0;
        run_to(62);
        chk("illegal_off", {29'd0, state}, 32'd0);
        enable = 1'b1;

        // Reset pulse during HUB_RST, then restart
        run_to(72);
        chk("mr_wait_rso", {29'd0, state}, 32'd3);
        run_to(73);
        chk("mr_hub_rst", {29'd0, state}, 32'd4);
        run_to(74);
        reset = 1'b1;
        run_to(75);
        chk("mr_reset_state", {29'd0, state}, 32'd0);
        chk("mr_reset_outs", outs(), 32'b1000);
        reset = 1'b0;
        run_to(76);
        chk("mr_wait_dsp", {29'd0, state}, 32'd1);
        chk("mr_wait_dsp_outs", outs(), 32'b1000);
        run_to(77);
        chk("mr_pwron", {29'd0, state}, 32'd2);
        run_to(85);
        chk("mr_wait_rso2", {29'd0, state}, 32'd3);
        run_to(86);
        chk("mr_hub_rst2", {29'd0, state}, 32'd4);
        run_to(89);
        chk("mr_hub_c89", {29'd0, state}, 32'd4);
        run_to(90);
        chk("mr_run", {29'd0, state}, 32'd5);
        chk("mr_run_outs", outs(), 32'b0110);

        // enable and dsp_ready drop together
        run_to(92);
        enable    = 1'b0;
        dsp_ready = 1'b0;
        run_to(93);
        chk("both_low_off", {29'd0, state}, 32'd0);
        chk("both_low_outs", outs(), 32'b1000);

        // Reset-out timeout
        enable       = 1'b1;
        dsp_ready    = 1'b1;
        cpu_resetout = 1'b0;
        run_to(103);
        chk("to_wait_rso", {29'd0, state}, 32'd3);
        run_to(134);
        chk("to_wait_c134", {29'd0, state}, 32'd3);
        run_to(135);
        chk("to_fault", {29'd0, state}, 32'd6);
        chk("to_fault_outs", outs(), 32'b1001);
        run_to(136);
        dsp_ready = 1'b0;
        run_to(139);
        chk("to_fault_hold", {29'd0, state}, 32'd6);
        run_to(140);
        enable = 1'b0;
        run_to(141);
        chk("to_off", {29'd0, state}, 32'd0);
        chk("to_off_outs", outs(), 32'b1000);
        enable    = 1'b1;
        dsp_ready = 1'b1;

        // rso_s rises on the exact timeout cycle
        run_to(151);
        chk("race_wait_rso", {29'd0, state}, 32'd3);
        run_to(180);
        cpu_resetout = 1'b1;
        run_to(182);
        chk("race_wait_c182", {29'd0, state}, 32'd3);
        run_to(183);
        chk("race_hub_rst", {29'd0, state}, 32'd4);
        chk("race_outs", outs(), 32'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
